// File: rtl/remote_pkg.sv
// Shared definitions for the remote link: timing defaults, frame layout,
// serialiser states and small helpers used by both link ends.
package remote_pkg;

  localparam int DEFAULT_HALF_BIT    = 20000;
  localparam int DEFAULT_SYNC_HALVES = 4;

  localparam int FRAME_BITS  = 16;
  localparam int FRAME_HALVES = 2 * FRAME_BITS;

  localparam int BTN_MSB    = 15;
  localparam int BTN_LSB    = 12;
  localparam int KNOB_MSB   = 11;
  localparam int KNOB_LSB   = 4;
  localparam int PARITY_BIT = 0;

  typedef enum logic [1:0] {
    SYNC,
    DATA,
    TAIL
  } state_t;

  // Quadrature phase pair {A,B} to its position in the 00,01,11,10 cycle.
  function automatic logic [1:0] gray_to_bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Assemble the frame word; the parity bit makes the XOR of all bits 1.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] buttons,
                                                        input logic [7:0] position);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[BTN_MSB:BTN_LSB]   = buttons;
    f[KNOB_MSB:KNOB_LSB] = position;
    f[PARITY_BIT]        = ~^f;
    return f;
  endfunction

endpackage

// File: rtl/remote_encoder_if.sv
// Remote-side signals: raw user inputs in, serial line and frame flag out.
interface remote_encoder_if;
  logic [3:0] Buttons;
  logic       KnobA;
  logic       KnobB;
  logic       Output;
  logic       Sending;

  modport master (
    input  Buttons,
    input  KnobA,
    input  KnobB,
    output Output,
    output Sending
  );

  modport slave (
    output Buttons,
    output KnobA,
    output KnobB,
    input  Output,
    input  Sending
  );
endinterface

// File: rtl/quadrature_counter.sv
// Input synchroniser, quadrature step decode and 8-bit rotary position.
module quadrature_counter
  import remote_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] buttons_in,
  input  logic       knob_a,
  input  logic       knob_b,
  output logic [3:0] buttons,
  output logic [7:0] position
);

  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic [1:0] cur_bin;
  logic [1:0] prev_bin;
  logic       step_up;
  logic       step_down;

  // Two-stage synchroniser for all asynchronous inputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!nReset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {buttons_in, knob_a, knob_b};
      sync2 <= sync1;
    end
  end

  assign buttons = sync2[5:2];
  assign cur_ab  = sync2[1:0];

  // A single-phase change one place forward or back in the Gray cycle is a
  // step; a two-phase jump lands two places away and matches neither.
  always_comb begin
    cur_bin   = gray_to_bin(cur_ab);
    prev_bin  = gray_to_bin(prev_ab);
    step_up   = (cur_bin == prev_bin + 2'd1);
    step_down = (prev_bin == cur_bin + 2'd1);
  end

  // Previous phase pair and the wrapping position counter.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      prev_ab  <= '0;
      position <= '0;
    end else begin
      prev_ab <= cur_ab;
      if (step_up) begin
        position <= position + 8'd1;
      end else if (step_down) begin
        position <= position - 8'd1;
      end
    end
  end

endmodule

// File: rtl/remote_encoder.sv
// Remote transmitter: frame snapshot with odd parity and a differential-biphase
// serialiser framed by a low sync gap and a hold tail.
module remote_encoder
  import remote_pkg::*;
#(
  parameter int HALF_BIT    = DEFAULT_HALF_BIT,
  parameter int SYNC_HALVES = DEFAULT_SYNC_HALVES
) (
  input  logic             Clk,
  input  logic             nReset,
  remote_encoder_if.master link
);

  localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_BIT - 1);
  localparam logic [4:0]    SYNC_LAST = 5'(SYNC_HALVES - 1);
  localparam logic [4:0]    HALF_LAST = 5'(FRAME_HALVES - 1);

  logic [3:0]            buttons;
  logic [7:0]            position;
  logic [FRAME_BITS-1:0] frame_word;

  state_t                state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [4:0]            idx_q,     idx_d;
  logic                  out_q,     out_d;
  logic                  sending_q, sending_d;
  logic [FRAME_BITS-1:0] f_q,       f_d;

  logic                  half_end;
  logic [4:0]            next_half;

  quadrature_counter u_quad (
    .Clk        (Clk),
    .nReset     (nReset),
    .buttons_in (link.Buttons),
    .knob_a     (link.KnobA),
    .knob_b     (link.KnobB),
    .buttons    (buttons),
    .position   (position)
  );

  assign frame_word = build_frame(buttons, position);
  assign half_end   = (cnt_q == CNT_LAST);
  assign next_half  = idx_q + 5'd1;

  // Serialiser next-state: half-bit timing, line edges and snapshot load.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = half_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    out_d     = out_q;
    sending_d = sending_q;
    f_d       = f_q;

    case (state_q)
      SYNC: begin
        out_d = 1'b0;
        if (half_end) begin
          if (idx_q == SYNC_LAST) begin
            // Line is low here, so the leading boundary edge always rises.
            state_d   = DATA;
            idx_d     = '0;
            f_d       = frame_word;
            out_d     = 1'b1;
            sending_d = 1'b1;
          end else begin
            idx_d = next_half;
          end
        end
      end

      DATA: begin
        if (half_end) begin
          if (idx_q == HALF_LAST) begin
            state_d   = TAIL;
            idx_d     = '0;
            out_d     = ~out_q;
            sending_d = 1'b0;
          end else begin
            idx_d = next_half;
            // Even halves start a bit; odd halves are mid-bit for bit
            // 15 - next_half[4:1], which is its bitwise complement.
            if (!next_half[0] || f_q[~next_half[4:1]]) begin
              out_d = ~out_q;
            end
          end
        end
      end

      TAIL: begin
        if (half_end) begin
          if (idx_q == SYNC_LAST) begin
            state_d = SYNC;
            idx_d   = '0;
            out_d   = 1'b0;
          end else begin
            idx_d = next_half;
          end
        end
      end

      default: begin
        state_d   = SYNC;
        cnt_d     = '0;
        idx_d     = '0;
        out_d     = 1'b0;
        sending_d = 1'b0;
      end
    endcase
  end

  // Serialiser registers; reset abandons any frame in progress.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q   <= SYNC;
      cnt_q     <= '0;
      idx_q     <= '0;
      out_q     <= 1'b0;
      sending_q <= 1'b0;
      f_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      sending_q <= sending_d;
      f_q       <= f_d;
    end
  end

  assign link.Output  = out_q;
  assign link.Sending = sending_q;

endmodule

// File: tb/tb_remote_encoder.sv
// Directed bench for remote_encoder: line edges are timestamped and decoded
// by the bench, then compared with hand-computed frame words.
module tb_remote_encoder;

  localparam int H = 4;
  localparam int S = 4;
  localparam int WAIT_LIMIT = 2 * (2 * S + 32) * H + 20;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;

  remote_encoder_if bus ();

  remote_encoder #(
    .HALF_BIT    (H),
    .SYNC_HALVES (S)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .link   (bus)
  );

  always #5 Clk = ~Clk;

  int   cyc = 0;
  int   edges[$];
  logic prev_out = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   phase_bin = 0;

  always @(posedge Clk) cyc++;

  // Timestamp every line transition with the cycle of the edge that caused it.
  always @(negedge Clk) begin
    if (!$isunknown(bus.Output)) begin
      if (bus.Output != prev_out) edges.push_back(cyc);
      prev_out = bus.Output;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_phases();
    bus.KnobA = phase_bin[1];
    bus.KnobB = phase_bin[1] ^ phase_bin[0];
  endtask

  task automatic turn(input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      phase_bin = fwd ? (phase_bin + 1) % 4 : (phase_bin + 3) % 4;
      set_phases();
      idle(2);
    end
  endtask

  function automatic int level_at(input int t);
    int n = 0;
    foreach (edges[i]) if (edges[i] <= t) n++;
    return n & 1;
  endfunction

  // Wait for the next frame to begin; the edge log then holds only that frame.
  task automatic frame_start(input string tag, output int rise);
    int n = 0;
    while (bus.Sending !== 1'b0 && n < WAIT_LIMIT) begin @(negedge Clk); n++; end
    #1;
    edges.delete();
    while (bus.Sending !== 1'b1 && n < WAIT_LIMIT) begin @(negedge Clk); n++; end
    check({tag, " start"}, 32'(bus.Sending === 1'b1), 1);
    rise = cyc;
  endtask

  // Wait for the terminating edge, then check edge timing and decoded word.
  task automatic frame_end(input string tag, input logic [15:0] exp_f,
                           input int rise, output int fall);
    int n = 0;
    int exp_q[$];
    int bad = 0;
    logic [15:0] dec = '0;
    while (bus.Sending !== 1'b0 && n < WAIT_LIMIT) begin @(negedge Clk); n++; end
    fall = cyc;
    check({tag, " end"}, 32'(bus.Sending === 1'b0), 1);
    @(negedge Clk);
    #1;
    check({tag, " sending_len"}, fall - rise, 32 * H);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(rise + 2 * k * H);
      if (exp_f[15 - k]) exp_q.push_back(rise + (2 * k + 1) * H);
    end
    exp_q.push_back(rise + 32 * H);
    check({tag, " edge_count"}, edges.size(), exp_q.size());
    foreach (exp_q[i]) if (i >= edges.size() || edges[i] != exp_q[i]) bad++;
    check({tag, " edge_times"}, bad, 0);
    check({tag, " first_rising"}, level_at(rise + H / 2), 1);
    for (int j = 0; j < 16; j++) begin
      dec[15 - j] = 1'(level_at(rise + 2 * j * H + H / 2) ^
                       level_at(rise + (2 * j + 1) * H + H / 2));
    end
    check({tag, " word"}, dec, exp_f);
    check({tag, " parity_odd"}, ^dec, 1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] exp_f,
                           output int rise, output int fall);
    frame_start(tag, rise);
    frame_end(tag, exp_f, rise, fall);
  endtask

  int r0, rise, fall, rise2, fall2;

  initial begin
    bus.Buttons = 4'b0000;
    bus.KnobA   = 1'b0;
    bus.KnobB   = 1'b0;
    nReset      = 1'b0;
    idle(3);
    check("reset output", bus.Output, 0);
    check("reset sending", bus.Sending, 0);

    // Idle inputs: frame 0x0001, full sync before the first edge.
    nReset = 1'b1;
    r0 = cyc;
    run_frame("f0", 16'h0001, rise, fall);
    check("f0 sync_gap", rise - r0, S * H);
    idle(2);
    check("tail low", bus.Output, 0);
    run_frame("f0b", 16'h0001, rise2, fall2);
    check("frame gap", rise2 - fall, 2 * S * H);
    check("frame period", rise2 - rise, (2 * S + 32) * H);

    // Buttons 1010 and position at 0x5A.
    bus.Buttons = 4'b1010;
    turn(90, 1'b1);
    idle(4);
    run_frame("f1", 16'hA5A1, rise, fall);

    // One-cycle reset in DATA: line drops at once, then a full sync.
    frame_start("rst", rise);
    check("pre_reset output", bus.Output, 1);
    nReset = 1'b0;
    @(negedge Clk);
    check("mid reset output", bus.Output, 0);
    check("mid reset sending", bus.Sending, 0);
    nReset = 1'b1;
    r0 = cyc;
    run_frame("f2", 16'hA001, rise, fall);
    check("f2 sync_gap", rise - r0, S * H);

    // Quadrature steps: +5 -2 from zero gives 0x03.
    bus.Buttons = 4'b0000;
    turn(5, 1'b1);
    turn(2, 1'b0);
    idle(4);
    run_frame("f3", 16'h0031, rise, fall);

    // Six back from 0x03 wraps below zero to 0xFD.
    turn(6, 1'b0);
    idle(4);
    run_frame("f4", 16'h0FD0, rise, fall);

    // Both phases flip together: no step.
    phase_bin = (phase_bin + 2) % 4;
    set_phases();
    idle(4);
    run_frame("f5", 16'h0FD0, rise, fall);

    // Three forward from 0xFD wraps through 0xFF to 0x00.
    turn(3, 1'b1);
    idle(4);
    run_frame("f6", 16'h0001, rise, fall);

    // Buttons change mid-frame: current frame keeps the old word.
    frame_start("f7", rise);
    idle(10);
    bus.Buttons = 4'b0101;
    frame_end("f7", 16'h0001, rise, fall);
    run_frame("f8", 16'h5001, rise, fall);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
